// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: fetches 16-bit words, pairs
// immediate-class instructions with their second word and injects INT slots.
module fetch_stage #(
  parameter int unsigned     PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(16'h0000),
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(16'h0002),
  parameter logic [7:0]      NOP_OPCODE = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            int_req,
  output logic            id_valid,
  output logic [7:0]      id_opcode,
  output logic [15:0]     id_instr,
  output logic [15:0]     id_imm,
  output logic            id_imm_valid,
  output logic            id_int,
  output logic [PC_W-1:0] id_pc_ret
);

  typedef enum logic {S_FETCH, S_IMM} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     hold_q, hold_d;
  logic            pend_q, pend_d;

  logic            valid_d, imm_valid_d, int_d;
  logic [7:0]      opcode_d;
  logic [15:0]     instr_d, imm_d;
  logic [PC_W-1:0] pc_ret_d;
  logic [PC_W-1:0] pc_inc;

  assign imem_addr = pc_q;
  assign pc_inc    = pc_q + PC_W'(1);

  // State and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      id_valid     <= 1'b0;
      id_opcode    <= NOP_OPCODE;
      id_instr     <= '0;
      id_imm       <= '0;
      id_imm_valid <= 1'b0;
      id_int       <= 1'b0;
      id_pc_ret    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      id_valid     <= valid_d;
      id_opcode    <= opcode_d;
      id_instr     <= instr_d;
      id_imm       <= imm_d;
      id_imm_valid <= imm_valid_d;
      id_int       <= int_d;
      id_pc_ret    <= pc_ret_d;
    end
  end

  // Next-state and IF/ID load selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    pend_d      = pend_q | int_req;
    valid_d     = id_valid;
    opcode_d    = id_opcode;
    instr_d     = id_instr;
    imm_d       = id_imm;
    imm_valid_d = id_imm_valid;
    int_d       = id_int;
    pc_ret_d    = id_pc_ret;

    if (redirect_en) begin
      pc_d        = redirect_pc;
      state_d     = S_FETCH;
      hold_d      = '0;
      valid_d     = 1'b0;
      opcode_d    = NOP_OPCODE;
      instr_d     = '0;
      imm_d       = '0;
      imm_valid_d = 1'b0;
      int_d       = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        S_FETCH: begin
          if (pend_q) begin
            // Interrupt boundary: imem_data is discarded and refetched on return
            valid_d     = 1'b1;
            int_d       = 1'b1;
            opcode_d    = NOP_OPCODE;
            instr_d     = '0;
            imm_d       = '0;
            imm_valid_d = 1'b0;
            pc_ret_d    = pc_q;
            pc_d        = INT_VECTOR;
            pend_d      = int_req;
          end else if (imem_data[15:14] == 2'b01) begin
            hold_d      = imem_data;
            pc_d        = pc_inc;
            state_d     = S_IMM;
            valid_d     = 1'b0;
            opcode_d    = NOP_OPCODE;
            instr_d     = '0;
            imm_d       = '0;
            imm_valid_d = 1'b0;
            int_d       = 1'b0;
          end else begin
            valid_d     = 1'b1;
            opcode_d    = imem_data[15:8];
            instr_d     = imem_data;
            imm_d       = '0;
            imm_valid_d = 1'b0;
            int_d       = 1'b0;
            pc_ret_d    = pc_inc;
            pc_d        = pc_inc;
          end
        end
        S_IMM: begin
          valid_d     = 1'b1;
          opcode_d    = hold_q[15:8];
          instr_d     = hold_q;
          imm_d       = imem_data;
          imm_valid_d = 1'b1;
          int_d       = 1'b0;
          pc_ret_d    = pc_inc;
          pc_d        = pc_inc;
          state_d     = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction-level model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        int_req;
  logic        id_valid;
  logic [7:0]  id_opcode;
  logic [15:0] id_instr;
  logic [15:0] id_imm;
  logic        id_imm_valid;
  logic        id_int;
  logic [15:0] id_pc_ret;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .int_req(int_req), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_instr(id_instr), .id_imm(id_imm), .id_imm_valid(id_imm_valid),
    .id_int(id_int), .id_pc_ret(id_pc_ret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [15:0] mem [int];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'h1100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program counter, "waiting for immediate word" flag, pending interrupt
  logic [15:0] m_pc;
  bit          m_mid_imm;
  logic [15:0] m_first;
  bit          m_pend;
  bit          e_valid, e_int, e_immv;
  logic [7:0]  e_op;
  logic [15:0] e_instr, e_imm, e_pcret;

  task automatic m_bubble();
    e_valid = 0; e_int = 0; e_immv = 0; e_op = 8'h00; e_instr = 0; e_imm = 0;
  endtask

  task automatic model_step(input bit rn, input bit st, input bit rd,
                            input logic [15:0] rpc, input bit ir);
    logic [15:0] w;
    bit nxt_pend;
    if (!rn) begin
      m_pc = 0; m_mid_imm = 0; m_first = 0; m_pend = 0;
      m_bubble(); e_pcret = 0;
      return;
    end
    nxt_pend = m_pend | ir;
    if (rd) begin
      m_pc = rpc; m_mid_imm = 0; m_bubble();
    end else if (!st) begin
      if (m_mid_imm) begin
        e_valid = 1; e_int = 0; e_immv = 1; e_op = m_first[15:8];
        e_instr = m_first; e_imm = mem_rd(m_pc);
        m_pc = m_pc + 16'd1; e_pcret = m_pc; m_mid_imm = 0;
      end else if (m_pend) begin
        e_valid = 1; e_int = 1; e_immv = 0; e_op = 8'h00; e_imm = 0;
        e_pcret = m_pc; m_pc = 16'h0002; nxt_pend = ir;
      end else begin
        w = mem_rd(m_pc);
        m_pc = m_pc + 16'd1;
        if (w[15:14] == 2'b01) begin
          m_first = w; m_mid_imm = 1; m_bubble();
        end else begin
          e_valid = 1; e_int = 0; e_immv = 0; e_op = w[15:8];
          e_instr = w; e_imm = 0; e_pcret = m_pc;
        end
      end
    end
    m_pend = nxt_pend;
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      chk("id_int", 32'(id_int), 32'(e_int));
      chk("id_opcode", 32'(id_opcode), 32'(e_op));
      chk("id_imm_valid", 32'(id_imm_valid), 32'(e_immv));
      chk("id_imm", 32'(id_imm), 32'(e_imm));
      if (!e_valid || !e_int) chk("id_instr", 32'(id_instr), 32'(e_instr));
      if (e_valid) chk("id_pc_ret", 32'(id_pc_ret), 32'(e_pcret));
    end
  end

  task automatic tick(input bit rn = 1, input bit st = 0, input bit rd = 0,
                      input logic [15:0] rpc = 16'h0, input bit ir = 0);
    @(negedge clk);
    rst_n = rn; stall = st; redirect_en = rd; redirect_pc = rpc; int_req = ir;
    imem_data = mem_rd(imem_addr);
    model_step(rn, st, rd, rpc, ir);
    @(posedge clk);
    #2;
    checking = 1'b1;
  endtask

  initial begin
    rst_n = 0; stall = 0; redirect_en = 0; redirect_pc = 0; int_req = 0; imem_data = 0;
    mem[0] = 16'h0512; mem[1] = 16'h0A34;
    mem[4] = 16'h4203; mem[5] = 16'hBEEF;
    mem[16'h20] = 16'h4A11; mem[16'h21] = 16'h5555;
    mem[16'h40] = 16'h1234; mem[16'hFFFF] = 16'h2345;

    tick(0); tick(0);
    chk("rst id_valid", 32'(id_valid), 0);
    chk("rst id_opcode", 32'(id_opcode), 0);
    chk("rst imem_addr", 32'(imem_addr), 0);

    // Single-word instructions back to back
    tick();
    chk("t1 opcode", 32'(id_opcode), 32'h05);
    chk("t1 pc_ret", 32'(id_pc_ret), 1);
    chk("t1 valid", 32'(id_valid), 1);
    tick();
    chk("t1 opcode2", 32'(id_opcode), 32'h0A);
    chk("t1 pc", 32'(imem_addr), 2);

    // Immediate pair at 4/5, interrupt pulse while the second word is fetched
    tick(); tick();
    tick();
    chk("t2 bubble valid", 32'(id_valid), 0);
    chk("t2 bubble opcode", 32'(id_opcode), 0);
    tick(1, 0, 0, 0, 1);
    chk("t2 instr", 32'(id_instr), 32'h4203);
    chk("t2 imm", 32'(id_imm), 32'hBEEF);
    chk("t2 imm_valid", 32'(id_imm_valid), 1);
    chk("t2 pc_ret", 32'(id_pc_ret), 6);
    chk("t2 pc", 32'(imem_addr), 6);
    tick();
    chk("t3 int", 32'(id_int), 1);
    chk("t3 pc_ret", 32'(id_pc_ret), 6);
    chk("t3 opcode", 32'(id_opcode), 0);
    chk("t3 pc", 32'(imem_addr), 2);
    tick();
    chk("t3 int cleared", 32'(id_int), 0);

    // Walk to pc=8, stall 3 cycles with a level request, then one INT slot
    repeat (5) tick();
    chk("t4 pc", 32'(imem_addr), 8);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 1);
    tick(1, 1, 0, 0, 1);
    chk("t4 frozen pc", 32'(imem_addr), 8);
    chk("t4 frozen pc_ret", 32'(id_pc_ret), 8);
    chk("t4 frozen int", 32'(id_int), 0);
    tick();
    chk("t4 int", 32'(id_int), 1);
    chk("t4 int pc_ret", 32'(id_pc_ret), 8);
    tick();
    chk("t4 merged", 32'(id_int), 0);

    // Redirect beats stall while waiting for the immediate word
    tick(1, 0, 1, 16'h0020, 0);
    tick();
    tick(1, 1, 1, 16'h0040, 0);
    chk("t5 pc", 32'(imem_addr), 32'h40);
    chk("t5 bubble", 32'(id_valid), 0);
    tick();
    chk("t5 opcode", 32'(id_opcode), 32'h12);
    chk("t5 pc_ret", 32'(id_pc_ret), 32'h41);

    // Redirect keeps a same-edge request pending
    tick(1, 0, 1, 16'h0030, 1);
    chk("redir bubble", 32'(id_int), 0);
    tick();
    chk("redir int", 32'(id_int), 1);
    chk("redir pc_ret", 32'(id_pc_ret), 32'h30);

    // PC wrap, then reset mid-stream with a request present
    tick(1, 0, 1, 16'hFFFF, 0);
    tick();
    chk("t6 opcode", 32'(id_opcode), 32'h23);
    chk("t6 pc_ret", 32'(id_pc_ret), 0);
    chk("t6 pc", 32'(imem_addr), 0);
    tick();
    tick(0, 0, 0, 0, 1);
    chk("t6 rst valid", 32'(id_valid), 0);
    chk("t6 rst pc", 32'(imem_addr), 0);
    chk("t6 rst pc_ret", 32'(id_pc_ret), 0);
    tick();
    chk("t6 no int", 32'(id_int), 0);
    chk("t6 refetch", 32'(id_opcode), 32'h05);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode control unit.
- Drives instruction memory and captures 16-bit instruction words.
- Assembles two-word immediate instructions.
- Latches external interrupt requests and injects an INT slot at an instruction boundary, so decode sees INT=1 together with the return PC.

Parameters:
- PC_W, 16, program counter / instruction-memory address width.
- RESET_PC, 16'h0000, PC loaded on reset.
- INT_VECTOR, 16'h0002, PC loaded after an interrupt slot is injected.
- NOP_OPCODE, 8'h00, opcode driven on id_opcode during bubbles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- imem_addr, output, PC_W, instruction-memory address; combinational, equals pc.
- imem_data, input, 16, instruction word at imem_addr, valid in the same cycle.
- stall, input, 1, hazard stall: hold pc, state and all id_* registers.
- redirect_en, input, 1, taken jump/call/return from later stages.
- redirect_pc, input, PC_W, redirect target.
- int_req, input, 1, external interrupt request; single-cycle pulse or level.
- id_valid, output, 1, IF/ID slot holds a complete instruction or INT slot.
- id_opcode, output, 8, opcode to decode (instr[15:8]); NOP_OPCODE when bubble or INT.
- id_instr, output, 16, full first instruction word.
- id_imm, output, 16, immediate word; 0 when id_imm_valid=0.
- id_imm_valid, output, 1, id_imm is meaningful (opcode[7:6]==2'b01).
- id_int, output, 1, INT slot; feeds decode INT input.
- id_pc_ret, output, PC_W, address of the next unexecuted instruction (return PC for INT/CALL).

Behaviour:
- State machine: S_FETCH, S_IMM.
- Holding register: hold_instr[15:0].
- Pending flag: int_pending.
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC, state=S_FETCH, int_pending=0, hold_instr=0.
  - id_valid=0, id_opcode=NOP_OPCODE, id_instr=0, id_imm=0, id_imm_valid=0, id_int=0, id_pc_ret=0.
  - Reset mid-immediate discards the held word.
- Bubble means: id_valid=0, id_opcode=NOP_OPCODE, id_int=0, id_imm_valid=0; id_instr and id_imm cleared.
- int_pending is set on every edge where int_req=1, including during stall, redirect and S_IMM. Repeated requests while pending merge into one.
- Priority per edge: rst_n, then redirect_en, then stall, then normal operation.
- redirect_en=1:
  - pc=redirect_pc, state=S_FETCH, IF/ID loads a bubble, hold_instr discarded.
  - int_pending is kept; it is taken no earlier than the next edge.
- stall=1 (no redirect): pc, state, hold_instr and all id_* hold their values. Only int_pending may change.
- S_FETCH with int_pending=1 (interrupt boundary):
  - id_valid=1, id_int=1, id_opcode=NOP_OPCODE, id_pc_ret=pc.
  - pc=INT_VECTOR; imem_data is ignored.
  - int_pending clears unless int_req=1 on the same edge.
- S_FETCH, no interrupt, imem_data[15:14]==2'b01 (immediate class):
  - hold_instr=imem_data, pc=pc+1, state=S_IMM, IF/ID loads a bubble.
- S_FETCH, otherwise (single-word instruction):
  - id_valid=1, id_instr=imem_data, id_opcode=imem_data[15:8].
  - id_pc_ret=pc+1, pc=pc+1.
- S_IMM:
  - id_valid=1, id_instr=hold_instr, id_opcode=hold_instr[15:8], id_imm=imem_data, id_imm_valid=1.
  - id_pc_ret=pc+1, pc=pc+1, state=S_FETCH.
  - Interrupts are never taken in S_IMM.
- pc arithmetic wraps modulo 2^PC_W: all-ones + 1 gives 0, with no flag.
- Latency: a single-word instruction appears on id_* one edge after its fetch. An immediate instruction appears two edges after its first word is fetched.

Test Plan:
1. Reset, then imem returns 16'h0512 at 0 and 16'h0A34 at 1 (no stall) -> edge1: id_valid=1, id_opcode=8'h05, id_pc_ret=1; edge2: id_opcode=8'h0A, pc=2.
2. Word 16'h4203 at 4 followed by 16'hBEEF at 5 -> edge after the fetch of 4: bubble (id_valid=0, opcode=NOP_OPCODE); next edge: id_instr=16'h4203, id_imm=16'hBEEF, id_imm_valid=1, id_pc_ret=6, pc=6.
3. int_req pulse while in S_IMM at pc=5 -> immediate instruction completes; next edge: id_int=1, id_pc_ret=6, id_opcode=NOP_OPCODE, pc=INT_VECTOR; one edge later int_pending=0 and id_int=0.
4. stall=1 for 3 cycles at pc=8 with an int_req pulse during the stall -> pc=8 and id_* frozen throughout; first unstalled edge injects INT with id_pc_ret=8.
5. redirect_en=1, redirect_pc=16'h0040 asserted together with stall=1 while in S_IMM -> pc=16'h0040, state S_FETCH, bubble, held word dropped; next edge fetches from 16'h0040.
6. pc=16'hFFFF, single-word instruction -> id_pc_ret=16'h0000, pc wraps to 0; rst_n low mid-stream -> all outputs return to reset values on that edge.
